// File: rtl/alu64.sv
// Registered integer ALU: combines a and b per a 4-bit opcode and registers
// the result together with zero, carry and signed-overflow status flags.
module alu64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpNor   = 4'b0101;
  localparam logic [3:0] OpSll   = 4'b0110;
  localparam logic [3:0] OpSrl   = 4'b0111;
  localparam logic [3:0] OpSra   = 4'b1000;
  localparam logic [3:0] OpSlt   = 4'b1001;
  localparam logic [3:0] OpSltu  = 4'b1010;
  localparam logic [3:0] OpPassb = 4'b1011;

  logic [WIDTH-1:0]        out_d, out_q;
  logic                    zero_d, zero_q;
  logic                    carry_d, carry_q;
  logic                    overflow_d, overflow_q;

  logic [WIDTH:0]          add_ext;
  logic [WIDTH:0]          sub_ext;
  logic [ShW-1:0]          shamt;
  logic signed [WIDTH-1:0] sra_res;

  assign shamt = b[ShW-1:0];

  // Subtraction as a + ~b + 1 so the carry-out directly means "no borrow".
  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b};
    sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sra_res = $signed(a) >>> shamt;
  end

  always_comb begin
    out_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op)
      OpAdd: begin
        out_d      = add_ext[WIDTH-1:0];
        carry_d    = add_ext[WIDTH];
        overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        out_d      = sub_ext[WIDTH-1:0];
        carry_d    = sub_ext[WIDTH];
        overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:   out_d = a & b;
      OpOr:    out_d = a | b;
      OpXor:   out_d = a ^ b;
      OpNor:   out_d = ~(a | b);
      OpSll:   out_d = a << shamt;
      OpSrl:   out_d = a >> shamt;
      OpSra:   out_d = sra_res;
      OpSlt:   out_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu:  out_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OpPassb: out_d = b;
      default: out_d = '0;
    endcase
    zero_d = (out_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu64.sv
// Self-checking bench for alu64: directed vector table, async-reset sequences
// and randomized operations compared against a behavioural model.
module tb_alu64;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] exp_out;
    logic        exp_zero;
    logic        exp_carry;
    logic        exp_ovf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  op;
  logic [63:0] out;
  logic        zero;
  logic        carry;
  logic        overflow;

  int checks;
  int errors;

  alu64 #(.WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .op       (op),
    .out      (out),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [63:0] e_out, input logic e_zero,
                         input logic e_carry, input logic e_ovf);
    chk({name, ".out"}, out, e_out);
    chk({name, ".zero"}, {63'd0, zero}, {63'd0, e_zero});
    chk({name, ".carry"}, {63'd0, carry}, {63'd0, e_carry});
    chk({name, ".ovf"}, {63'd0, overflow}, {63'd0, e_ovf});
  endtask

  // Reference computed from the arithmetic definitions with wide signed/unsigned math.
  function automatic vec_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic [3:0] mop);
    vec_t v;
    logic [64:0]        wide;
    logic signed [65:0] sw;
    int                 sh;
    logic [63:0]        fill;
    sh = int'(mb[5:0]);
    v.a = ma; v.b = mb; v.op = mop;
    v.exp_out = 64'd0; v.exp_carry = 1'b0; v.exp_ovf = 1'b0;
    case (mop)
      4'd0: begin
        wide = {1'b0, ma} + {1'b0, mb};
        v.exp_out = wide[63:0];
        v.exp_carry = wide[64];
        sw = $signed({{2{ma[63]}}, ma}) + $signed({{2{mb[63]}}, mb});
        v.exp_ovf = (sw != $signed({{2{sw[63]}}, sw[63:0]}));
      end
      4'd1: begin
        v.exp_out = ma - mb;
        v.exp_carry = (ma >= mb);
        sw = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb});
        v.exp_ovf = (sw != $signed({{2{sw[63]}}, sw[63:0]}));
      end
      4'd2: v.exp_out = ma & mb;
      4'd3: v.exp_out = ma | mb;
      4'd4: v.exp_out = ma ^ mb;
      4'd5: v.exp_out = ~(ma | mb);
      4'd6: v.exp_out = ma << sh;
      4'd7: v.exp_out = ma >> sh;
      4'd8: begin
        fill = ma[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0;
        v.exp_out = (ma >> sh) | fill;
      end
      4'd9:  v.exp_out = ($signed(ma) < $signed(mb)) ? 64'd1 : 64'd0;
      4'd10: v.exp_out = (ma < mb) ? 64'd1 : 64'd0;
      4'd11: v.exp_out = mb;
      default: v.exp_out = 64'd0;
    endcase
    v.exp_zero = (v.exp_out == 64'd0);
    return v;
  endfunction

  vec_t vecs[$];
  vec_t m;

  initial begin
    checks = 0;
    errors = 0;

    vecs.push_back('{64'd0, 64'd0, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{64'd1, 64'd2, 4'h0, 64'd3, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 64'd0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 64'h8000_0000_0000_0000,
                     1'b0, 1'b0, 1'b1});
    vecs.push_back('{64'd5, 64'd5, 4'h1, 64'd0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{64'd3, 64'd5, 4'h1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'd1, 4'h1, 64'h7FFF_FFFF_FFFF_FFFF,
                     1'b0, 1'b1, 1'b1});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'd63, 4'h8, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'd63, 4'h7, 64'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'd1, 64'h40, 4'h6, 64'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'd1, 64'hFF04, 4'h6, 64'd16, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h9, 64'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'hA, 64'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{64'hF0F0, 64'hFF00, 4'h2, 64'hF000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'hF0F0, 64'hFF00, 4'h3, 64'hFFF0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'hF0F0, 64'hFF00, 4'h4, 64'h0FF0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'd0, 64'd0, 4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'd7, 64'h1234_5678_9ABC_DEF0, 4'hB, 64'h1234_5678_9ABC_DEF0,
                     1'b0, 1'b0, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'hC, 64'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0});

    // Reset state, held across an edge, then released mid-cycle.
    rst = 1'b1;
    a = 64'd5; b = 64'd7; op = 4'h0;
    #3;
    chk_all("reset", 64'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("reset_held", 64'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("reset_release", 64'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("first_edge", 64'd12, 1'b0, 1'b0, 1'b0);

    // Directed table, one operation per cycle.
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_zero,
              vecs[i].exp_carry, vecs[i].exp_ovf);
    end

    // Asynchronous reset mid-run with a nonzero result, no clock edge involved.
    a = 64'd1; b = 64'd2; op = 4'h0;
    @(posedge clk); #1;
    chk_all("pre_async", 64'd3, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 64'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("async_release", 64'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("after_async", 64'd3, 1'b0, 1'b0, 1'b0);

    // Randomized operations against the model, with biased operand corners.
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = {a[63], 63'h7FFF_FFFF_FFFF_FFFF};
        2: b = 64'($urandom_range(0, 70));
        default: ;
      endcase
      m = model(a, b, op);
      @(posedge clk); #1;
      chk_all($sformatf("rand%0d_op%0d", i, op), m.exp_out, m.exp_zero, m.exp_carry,
              m.exp_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
